// File: rtl/can_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// can_interrupt_ctrl
//
// Sticky interrupt status block for the CAN core. Each of the N_IRQ event
// sources passes through an optional synchroniser and is then qualified as
// a level or a rising-edge event, depending on its mode bit. An event sets a
// sticky status bit. An event that arrives while the status bit is already
// set also sets a sticky miss bit. Software clears both bits by writing 1s
// through the clear strobe. The enable register masks status into pending.
// The OR of pending drives a registered CPU interrupt line, and a
// registered ID reports the lowest-index pending channel.
//
// Ports:
//   sys_clk                in   system clock, rising edge
//   sys_rst_n              in   asynchronous active-low reset
//   irq_src[N_IRQ]         in   raw event sources from the CAN core
//   en_we / mode_we        in   write strobes for the enable / mode registers
//   clr_we                 in   write strobe for write-1-to-clear of status/miss
//   DEMUX2interrupt_wdata  in   shared write data for the three strobes
//   interruptstat2MUX      out  sticky raw status (zero-extended)
//   interruptpend2MUX      out  status & enable (zero-extended)
//   interruptmiss2MUX      out  sticky overflow (zero-extended)
//   interrupten2MUX        out  enable register readback
//   interruptmode2MUX      out  mode readback, 1 = rising edge, 0 = level
//   irq                    out  registered OR of pending
//   irq_id                 out  lowest pending channel index, 0 when idle
// ---------------------------------------------------------------------------
module can_interrupt_ctrl #(
    parameter int N_IRQ       = 12,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_IRQ-1:0]  irq_src,
    input  logic              en_we,
    input  logic              mode_we,
    input  logic              clr_we,
    input  logic [DATA_W-1:0] DEMUX2interrupt_wdata,
    output logic [DATA_W-1:0] interruptstat2MUX,
    output logic [DATA_W-1:0] interruptpend2MUX,
    output logic [DATA_W-1:0] interruptmiss2MUX,
    output logic [DATA_W-1:0] interrupten2MUX,
    output logic [DATA_W-1:0] interruptmode2MUX,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id
);

    logic [N_IRQ-1:0] src_s;      // synchronised sources
    logic [N_IRQ-1:0] src_prev;   // edge history, one cycle behind src_s
    logic [N_IRQ-1:0] status;
    logic [N_IRQ-1:0] miss;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] mode;
    logic [N_IRQ-1:0] wdata;
    logic [N_IRQ-1:0] clr_mask;
    logic [N_IRQ-1:0] event_v;
    logic [N_IRQ-1:0] pending;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_index(input logic [N_IRQ-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    assign wdata = DEMUX2interrupt_wdata[N_IRQ-1:0];

    generate
        if (DATA_W > N_IRQ) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^DEMUX2interrupt_wdata[DATA_W-1:N_IRQ];
        end
    endgenerate

    // Input synchroniser stage
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign src_s = irq_src;
        end else begin : g_sync
            logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= irq_src;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Event qualification. The edge history is updated in both modes, so a
    // mode switch never manufactures an edge. Because the history resets to 0,
    // a source that is already high at reset release produces exactly one edge.
    assign event_v  = (mode & src_s & ~src_prev) | (~mode & src_s);
    assign clr_mask = clr_we ? wdata : '0;
    assign pending  = status & enable;

    // Status / miss / configuration / interrupt output stage
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            src_prev <= '0;
            status   <= '0;
            miss     <= '0;
            enable   <= '0;
            mode     <= '0;
            irq      <= 1'b0;
            irq_id   <= '0;
        end else begin
            src_prev <= src_s;
            // A set has priority over a clear in the same cycle.
            status   <= event_v | (status & ~clr_mask);
            // A same-cycle clear suppresses the overflow flag, because the new
            // event is then the only one that software has not yet seen.
            miss     <= (event_v & status & ~clr_mask) | (miss & ~clr_mask);
            if (en_we)   enable <= wdata;
            if (mode_we) mode   <= wdata;
            irq      <= |pending;
            irq_id   <= lowest_index(pending);
        end
    end

    assign interruptstat2MUX = DATA_W'(status);
    assign interruptpend2MUX = DATA_W'(pending);
    assign interruptmiss2MUX = DATA_W'(miss);
    assign interrupten2MUX   = DATA_W'(enable);
    assign interruptmode2MUX = DATA_W'(mode);

endmodule

// File: tb/tb_can_interrupt_ctrl.sv
module tb_can_interrupt_ctrl;

    logic        clk;
    logic        rst_n;
    logic [11:0] src;
    logic        en_we;
    logic        mode_we;
    logic        clr_we;
    logic [31:0] wdata;
    logic [31:0] stat;
    logic [31:0] pend;
    logic [31:0] miss;
    logic [31:0] en_rb;
    logic [31:0] mode_rb;
    logic        irq;
    logic [4:0]  irq_id;

    int n_cmp = 0;
    int n_err = 0;

    can_interrupt_ctrl #(
        .N_IRQ(12), .DATA_W(32), .SYNC_STAGES(2), .ID_W(5)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .irq_src(src),
        .en_we(en_we),
        .mode_we(mode_we),
        .clr_we(clr_we),
        .DEMUX2interrupt_wdata(wdata),
        .interruptstat2MUX(stat),
        .interruptpend2MUX(pend),
        .interruptmiss2MUX(miss),
        .interrupten2MUX(en_rb),
        .interruptmode2MUX(mode_rb),
        .irq(irq),
        .irq_id(irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle register write; any combination of strobes may be set.
    task automatic wr(input logic e, input logic m, input logic c, input logic [31:0] d);
        en_we = e; mode_we = m; clr_we = c; wdata = d;
        tick(1);
        en_we = 0; mode_we = 0; clr_we = 0; wdata = '0;
    endtask

    // One-cycle pulse on the raw sources, followed by enough cycles for the
    // two-flop synchroniser plus the status register.
    task automatic pulse(input logic [11:0] p);
        src = p;
        tick(1);
        src = '0;
        tick(3);
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick(2);
        n_cmp++; if (stat !== 32'h0) begin n_err++; $display("FAIL reset_stat got %h want %h", stat, 32'h0); end
        n_cmp++; if (pend !== 32'h0 || miss !== 32'h0) begin n_err++; $display("FAIL reset_pend_miss got %h/%h want 0/0", pend, miss); end
        n_cmp++; if (en_rb !== 32'h0 || mode_rb !== 32'h0) begin n_err++; $display("FAIL reset_en_mode got %h/%h want 0/0", en_rb, mode_rb); end
        n_cmp++; if (irq !== 1'b0 || irq_id !== 5'd0) begin n_err++; $display("FAIL reset_irq got %b/%0d want 0/0", irq, irq_id); end
        rst_n = 1;
        tick(1);
    endtask

    task automatic test_edge_latency;
        // Enable and mode are written in the same cycle.
        wr(1, 1, 0, 32'h004);
        n_cmp++; if (en_rb !== 32'h004 || mode_rb !== 32'h004) begin n_err++; $display("FAIL t1_en_mode got %h/%h want 004/004", en_rb, mode_rb); end
        src = 12'h004;
        tick(1);
        src = '0;
        tick(1);
        n_cmp++; if (stat !== 32'h0) begin n_err++; $display("FAIL t1_stat_early got %h want %h", stat, 32'h0); end
        tick(1);
        n_cmp++; if (stat !== 32'h004 || irq !== 1'b0) begin n_err++; $display("FAIL t1_stat_c3 got %h irq %b want 004 irq 0", stat, irq); end
        tick(1);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 5'd2) begin n_err++; $display("FAIL t1_irq_c4 got %b/%0d want 1/2", irq, irq_id); end
        n_cmp++; if (miss !== 32'h0) begin n_err++; $display("FAIL t1_miss got %h want %h", miss, 32'h0); end
        wr(0, 0, 1, 32'h004);
        tick(1);
        n_cmp++; if (stat !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL t1_cleanup got %h/%b want 0/0", stat, irq); end
    endtask

    task automatic test_level_set_wins;
        wr(1, 1, 0, 32'h001);
        wr(0, 1, 0, 32'h000);
        src = 12'h001;
        tick(4);
        n_cmp++; if (stat !== 32'h001 || irq !== 1'b1) begin n_err++; $display("FAIL t2_level_set got %h/%b want 001/1", stat, irq); end
        // Held level source re-asserts every cycle, so the overflow flag is set.
        n_cmp++; if (miss !== 32'h001) begin n_err++; $display("FAIL t2_level_miss got %h want %h", miss, 32'h001); end
        wr(0, 0, 1, 32'h001);
        n_cmp++; if (stat !== 32'h001) begin n_err++; $display("FAIL t2_set_wins got %h want %h", stat, 32'h001); end
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL t2_irq_held got %b want 1", irq); end
        src = '0;
        tick(3);
        wr(0, 0, 1, 32'h001);
        n_cmp++; if (stat !== 32'h0 || miss !== 32'h0) begin n_err++; $display("FAIL t2_cleared got %h/%h want 0/0", stat, miss); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL t2_irq_lag got %b want 1", irq); end
        tick(1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL t2_irq_drop got %b want 0", irq); end
    endtask

    task automatic test_miss;
        wr(1, 1, 0, 32'h080);
        pulse(12'h080);
        n_cmp++; if (stat !== 32'h080 || miss !== 32'h0) begin n_err++; $display("FAIL t3_first got %h/%h want 080/0", stat, miss); end
        pulse(12'h080);
        n_cmp++; if (stat !== 32'h080 || miss !== 32'h080) begin n_err++; $display("FAIL t3_second got %h/%h want 080/080", stat, miss); end
        wr(0, 0, 1, 32'h080);
        n_cmp++; if (stat !== 32'h0 || miss !== 32'h0) begin n_err++; $display("FAIL t3_clear got %h/%h want 0/0", stat, miss); end
        tick(1);
    endtask

    task automatic test_enable_mask;
        wr(1, 1, 0, 32'h000);
        wr(0, 1, 0, 32'h200);
        pulse(12'h200);
        tick(1);
        n_cmp++; if (stat !== 32'h200 || pend !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL t4_masked got %h/%h/%b want 200/0/0", stat, pend, irq); end
        wr(1, 0, 0, 32'h200);
        n_cmp++; if (pend !== 32'h200 || irq !== 1'b0) begin n_err++; $display("FAIL t4_pend got %h/%b want 200/0", pend, irq); end
        tick(1);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 5'd9) begin n_err++; $display("FAIL t4_irq got %b/%0d want 1/9", irq, irq_id); end
        // Disabling keeps status but drops irq one cycle later.
        wr(1, 0, 0, 32'h000);
        tick(1);
        n_cmp++; if (stat !== 32'h200 || irq !== 1'b0) begin n_err++; $display("FAIL t4_disable got %h/%b want 200/0", stat, irq); end
        wr(0, 0, 1, 32'h200);
    endtask

    task automatic test_priority;
        wr(1, 1, 0, 32'h012);
        pulse(12'h012);
        tick(1);
        n_cmp++; if (stat !== 32'h012 || irq_id !== 5'd1) begin n_err++; $display("FAIL t5_id1 got %h/%0d want 012/1", stat, irq_id); end
        wr(0, 0, 1, 32'h002);
        tick(1);
        n_cmp++; if (stat !== 32'h010 || irq_id !== 5'd4 || irq !== 1'b1) begin n_err++; $display("FAIL t5_id4 got %h/%0d/%b want 010/4/1", stat, irq_id, irq); end
        wr(0, 0, 1, 32'h010);
        tick(1);
        n_cmp++; if (irq !== 1'b0 || irq_id !== 5'd0) begin n_err++; $display("FAIL t5_idle got %b/%0d want 0/0", irq, irq_id); end
    endtask

    task automatic test_async_reset;
        wr(1, 1, 0, 32'hFFF);
        pulse(12'hFFF);
        tick(1);
        n_cmp++; if (stat !== 32'hFFF || irq !== 1'b1 || irq_id !== 5'd0) begin n_err++; $display("FAIL t6_full got %h/%b/%0d want fff/1/0", stat, irq, irq_id); end
        src = 12'h008;
        #3;
        rst_n = 0;
        #1;
        n_cmp++; if (stat !== 32'h0 || en_rb !== 32'h0 || mode_rb !== 32'h0 || irq !== 1'b0) begin n_err++; $display("FAIL t6_async got %h/%h/%h/%b want all 0", stat, en_rb, mode_rb, irq); end
        tick(2);
        rst_n = 1;
        en_we = 1; mode_we = 1; wdata = 32'h008;
        tick(1);
        en_we = 0; mode_we = 0; wdata = '0;
        tick(1);
        n_cmp++; if (stat !== 32'h0) begin n_err++; $display("FAIL t6_early got %h want %h", stat, 32'h0); end
        tick(1);
        n_cmp++; if (stat !== 32'h008) begin n_err++; $display("FAIL t6_event got %h want %h", stat, 32'h008); end
        tick(1);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 5'd3) begin n_err++; $display("FAIL t6_irq got %b/%0d want 1/3", irq, irq_id); end
        tick(4);
        n_cmp++; if (miss !== 32'h0 || stat !== 32'h008) begin n_err++; $display("FAIL t6_single got %h/%h want 0/008", miss, stat); end
        src = '0;
    endtask

    initial begin
        rst_n = 0; src = '0; en_we = 0; mode_we = 0; clr_we = 0; wdata = '0;
        #2;
        test_reset();
        test_edge_latency();
        test_level_set_wins();
        test_miss();
        test_enable_mask();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/can_interrupt_ctrl.md
Name: can_interrupt_ctrl

Overview:
- Parametrised successor to the CAN core's combinational interrupt status block.
- Captures N_IRQ CAN event sources (WKUP, SLP, BSOFF, ERROR, RXNEMP, RXOFLW, RXUFLW, RXOK, TXBFLL, TXFLL, TXOK, ARBLST at default) into sticky status bits.
- Each channel has an optional input synchroniser and a per-channel level/rising-edge mode, with enable masking and write-1-to-clear.
- Drives one registered CPU interrupt line plus a lowest-index pending ID; status, pending and overflow vectors go to the register read MUX.

Parameters:
- N_IRQ, 12, number of interrupt channels (1..32); bit i = source i.
- DATA_W, 32, register bus width; bits [DATA_W-1:N_IRQ] of all read vectors are 0.
- SYNC_STAGES, 2, synchroniser flops per source (0 = bypass, max 3).
- ID_W, 5, width of irq_id (must be >= clog2(N_IRQ)).

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- irq_src  in  N_IRQ  raw event sources from CAN core.
- en_we  in  1  single-cycle write strobe for enable register.
- mode_we  in  1  single-cycle write strobe for mode register.
- clr_we  in  1  single-cycle write strobe for W1C clear.
- DEMUX2interrupt_wdata  in  DATA_W  write data for en/mode/clr.
- interruptstat2MUX  out  DATA_W  sticky raw status.
- interruptpend2MUX  out  DATA_W  status & enable.
- interruptmiss2MUX  out  DATA_W  sticky overflow (event while already set).
- interrupten2MUX  out  DATA_W  enable register readback.
- interruptmode2MUX  out  DATA_W  mode readback (1 = rising edge, 0 = level).
- irq  out  1  registered OR of pending.
- irq_id  out  ID_W  lowest-index pending channel; 0 when irq=0.

Behaviour:
- Reset (async, sys_rst_n=0): clear all sync flops, edge-history flops, status, miss, enable, mode, irq and irq_id. All outputs read 0.
- Synchroniser: s[i] = irq_src[i] delayed SYNC_STAGES cycles; SYNC_STAGES=0 uses irq_src directly.
- Edge history: p[i] <= s[i] every cycle, independent of mode, so a mode change creates no spurious edge. p resets to 0; a source already high at reset release yields one edge event.
- Event: ev[i] = mode[i] ? (s[i] & ~p[i]) : s[i].
- Status update per cycle, per bit:
  - ev=1: status <= 1. Set wins over a same-cycle clear.
  - else, clr_we & wdata[i]: status <= 0.
  - else: hold.
- Level-mode channel with the source still high re-sets the cycle after a clear.
- Miss update per bit:
  - ev & status & ~(clr_we & wdata[i]): miss <= 1.
  - else, clr_we & wdata[i]: miss <= 0.
- Events set status regardless of enable. Enable masks only pending/irq.
- en_we: enable <= wdata[N_IRQ-1:0]. mode_we: mode <= wdata[N_IRQ-1:0]. Strobes may coincide; each acts on its own register.
- pending = status & enable, combinational from registers.
- irq <= |pending, one cycle after pending changes.
- irq_id <= index of lowest set pending bit, registered with irq.
- Latency from irq_src edge to status: SYNC_STAGES+1 cycles. To irq: SYNC_STAGES+2.
- Clearing the last pending bit drops irq one cycle after the clear write.
- Disabling a set channel drops irq one cycle after en_we; status is retained.

Test Plan:
1. Reset with irq_src=0, then SYNC_STAGES=2, mode=0x004, enable=0x004, pulse irq_src[2] one cycle -> status=0x004 at cycle 3, irq=1 and irq_id=2 at cycle 4, miss=0.
2. Level mode on ch0, enable=0x001, hold irq_src[0]=1 and write clr 0x001 -> status stays 0x001 (set wins), irq stays 1. Drop source, clear again -> status=0, irq=0 one cycle later.
3. Edge mode on ch7, two pulses with no clear between -> status=0x080, miss=0x080. Clear 0x080 -> both 0.
4. Enable=0x000, pulse ch9 -> status=0x200, pending=0, irq=0. Write enable=0x200 -> irq=1, irq_id=9 one cycle later.
5. Status=0x012 with ch1 and ch4 enabled -> irq_id=1. Clear 0x002 -> irq_id=4. Clear 0x010 -> irq=0, irq_id=0.
6. Assert sys_rst_n=0 mid-operation with status=0xFFF -> all outputs 0 immediately (async). Release with irq_src[3]=1 in edge mode -> one event on ch3 after SYNC_STAGES+1 cycles.
